// File: rtl/demod_8psk_frame_if.sv
// Sample/strobe bus between symbol timing recovery, the 8PSK slicer
// and the downstream RS decoder.
interface demod_8psk_frame_if #(
   parameter int N_SYM = 108
);
   logic signed [19:0]   rx_i;
   logic signed [19:0]   rx_q;
   logic                 ena_in;
   logic                 sof;
   logic [2:0]           sym_out;
   logic                 sym_valid;
   logic [3*N_SYM-1:0]   data_8psk_rx;
   logic                 ena_out;
   logic                 frame_abort;
   logic                 busy;

   modport master (
      output rx_i, rx_q, ena_in, sof,
      input  sym_out, sym_valid, data_8psk_rx,
      input  ena_out, frame_abort, busy
   );

   modport slave (
      input  rx_i, rx_q, ena_in, sof,
      output sym_out, sym_valid, data_8psk_rx,
      output ena_out, frame_abort, busy
   );
endinterface

// File: rtl/demod_8psk_frame.sv
// Hard-decision 8PSK slicer with MSB-first frame packing into the
// 3*N_SYM-bit RS codeword.
module demod_8psk_frame #(
   parameter int N_SYM = 108,
   parameter int TAN_Q = 424,
   parameter int SHIFT = 10
) (
   input logic              clk,
   input logic              reset_b,
   demod_8psk_frame_if.slave bus
);
   localparam int W  = 3 * N_SYM;
   localparam int CW = $clog2(N_SYM + 1);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   logic [19:0]   ri;
   logic [19:0]   rq;
   logic [19:0]   a_q, a_d;
   logic [19:0]   b_q, b_d;
   logic          si_q, si_d;
   logic          sq_q, sq_d;
   logic          sof1_q, sof1_d;
   logic          v1_q, v1_d;

   logic [30:0]   a_sh, b_sh;
   logic [30:0]   a_tan, b_tan;
   logic          near_re, near_im;
   logic [2:0]    dec;
   logic [2:0]    sym_q, sym_d;
   logic          sym_valid_q, sym_valid_d;
   logic          sof2_q, sof2_d;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [W-1:0]  shadow_q, shadow_d;
   logic [W-1:0]  data_q, data_d;
   logic          ena_out_q, ena_out_d;
   logic          abort_q, abort_d;

   assign ri = bus.rx_i;
   assign rq = bus.rx_q;

   // Magnitudes are 20-bit unsigned, so -2^19 folds to 2^19 cleanly.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      si_d   = si_q;
      sq_d   = sq_q;
      sof1_d = sof1_q;
      v1_d   = bus.ena_in;
      if (bus.ena_in) begin
         a_d    = ri[19] ? (~ri + 20'd1) : ri;
         b_d    = rq[19] ? (~rq + 20'd1) : rq;
         si_d   = ri[19];
         sq_d   = rq[19];
         sof1_d = bus.sof;
      end
   end

   assign a_sh  = {11'd0, a_q} << SHIFT;
   assign b_sh  = {11'd0, b_q} << SHIFT;
   assign a_tan = {11'd0, a_q} * 31'(TAN_Q);
   assign b_tan = {11'd0, b_q} * 31'(TAN_Q);

   // Strict compares: exact ties and the origin land on a diagonal.
   assign near_re = b_sh < a_tan;
   assign near_im = a_sh < b_tan;

   always_comb begin
      dec = 3'd1;
      unique case (1'b1)
         near_re: dec = si_q ? 3'd4 : 3'd0;
         near_im: dec = sq_q ? 3'd6 : 3'd2;
         default: begin
            unique case ({si_q, sq_q})
               2'b00:   dec = 3'd1;
               2'b10:   dec = 3'd3;
               2'b11:   dec = 3'd5;
               default: dec = 3'd7;
            endcase
         end
      endcase
   end

   always_comb begin
      sym_d       = v1_q ? dec : sym_q;
      sym_valid_d = v1_q;
      sof2_d      = v1_q & sof1_q;
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      shadow_d  = shadow_q;
      data_d    = data_q;
      ena_out_d = 1'b0;
      abort_d   = 1'b0;
      if (sym_valid_q) begin
         unique case (state_q)
            IDLE: begin
               if (sof2_q) begin
                  shadow_d            = '0;
                  shadow_d[W-1 -: 3]  = sym_q;
                  count_d             = CW'(1);
                  state_d             = COLLECT;
               end
            end
            default: begin
               if (sof2_q) begin
                  abort_d             = 1'b1;
                  shadow_d            = '0;
                  shadow_d[W-1 -: 3]  = sym_q;
                  count_d             = CW'(1);
               end else begin
                  for (int k = 0; k < N_SYM; k++) begin
                     if (k == int'(count_q))
                        shadow_d[3*(N_SYM-1-k) +: 3] = sym_q;
                  end
                  count_d = count_q + CW'(1);
                  if (int'(count_q) == N_SYM - 1) begin
                     data_d    = shadow_d;
                     ena_out_d = 1'b1;
                     count_d   = '0;
                     state_d   = IDLE;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         a_q         <= '0;
         b_q         <= '0;
         si_q        <= 1'b0;
         sq_q        <= 1'b0;
         sof1_q      <= 1'b0;
         v1_q        <= 1'b0;
         sym_q       <= '0;
         sym_valid_q <= 1'b0;
         sof2_q      <= 1'b0;
         state_q     <= IDLE;
         count_q     <= '0;
         shadow_q    <= '0;
         data_q      <= '0;
         ena_out_q   <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         si_q        <= si_d;
         sq_q        <= sq_d;
         sof1_q      <= sof1_d;
         v1_q        <= v1_d;
         sym_q       <= sym_d;
         sym_valid_q <= sym_valid_d;
         sof2_q      <= sof2_d;
         state_q     <= state_d;
         count_q     <= count_d;
         shadow_q    <= shadow_d;
         data_q      <= data_d;
         ena_out_q   <= ena_out_d;
         abort_q     <= abort_d;
      end
   end

   assign bus.sym_out      = sym_q;
   assign bus.sym_valid    = sym_valid_q;
   assign bus.data_8psk_rx = data_q;
   assign bus.ena_out      = ena_out_q;
   assign bus.frame_abort  = abort_q;
   assign bus.busy         = (state_q == COLLECT);
endmodule

// File: tb/tb_demod_8psk_frame.sv
// Bench for demod_8psk_frame: vector table, random slicing against a
// sector model, and frame/abort/reset sequences.
module tb_demod_8psk_frame;
   localparam int N = 108;
   localparam int W = 3 * N;

   typedef struct {
      int         i;
      int         q;
      logic [2:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset_b = 1'b0;

   demod_8psk_frame_if #(.N_SYM(N)) bus ();

   demod_8psk_frame #(
      .N_SYM(N),
      .TAN_Q(424),
      .SHIFT(10)
   ) dut (
      .clk(clk),
      .reset_b(reset_b),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int tests = 0;
   int fails = 0;

   logic [2:0]   sq[$];
   int           sc[$];
   logic [2:0]   xq[$];
   int           xc[$];
   int           ec[$];
   logic [W-1:0] ed[$];
   int           ac[$];

   always @(negedge clk) begin
      if (bus.sym_valid) begin
         sq.push_back(bus.sym_out);
         sc.push_back(cyc);
      end
      if (bus.ena_out) begin
         ec.push_back(cyc);
         ed.push_back(bus.data_8psk_rx);
      end
      if (bus.frame_abort) ac.push_back(cyc);
   end

   // Nearest constellation point: within 22.5 deg of an axis means the
   // axis symbol; otherwise the diagonal of the quadrant. Ties go diagonal.
   function automatic logic [2:0] ref_sym(input int i, input int q);
      longint a, b;
      a = (i < 0) ? -longint'(i) : longint'(i);
      b = (q < 0) ? -longint'(q) : longint'(q);
      if (b * 1024 < a * 424) return (i < 0) ? 3'd4 : 3'd0;
      if (a * 1024 < b * 424) return (q < 0) ? 3'd6 : 3'd2;
      if (i >= 0) return (q >= 0) ? 3'd1 : 3'd7;
      return (q >= 0) ? 3'd3 : 3'd5;
   endfunction

   task automatic chk(input string n, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic chkv(input string n, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic send(input int i, input int q, input bit s,
                       input logic [2:0] e);
      bus.rx_i   = 20'(i);
      bus.rx_q   = 20'(q);
      bus.ena_in = 1'b1;
      bus.sof    = s;
      xq.push_back(e);
      xc.push_back(cyc + 2);
      @(posedge clk);
      #1;
      bus.ena_in = 1'b0;
      bus.sof    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic flush_check(input string tag);
      int n;
      idle(4);
      chk({tag, "_count"}, sq.size(), xq.size());
      n = (sq.size() < xq.size()) ? sq.size() : xq.size();
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s_sym%0d", tag, k), sq[k], xq[k]);
         chk($sformatf("%s_lat%0d", tag, k), sc[k], xc[k]);
      end
      sq.delete();
      sc.delete();
      xq.delete();
      xc.delete();
   endtask

   vec_t tv[14];
   int   px[8];
   int   py[8];

   initial begin
      logic signed [19:0] r;
      logic [W-1:0]       ev;
      int                 ri, rq, c51, lastc;

      px = '{100000, 70711, 0, -70711, -100000, -70711, 0, 70711};
      py = '{0, 70711, 100000, 70711, 0, -70711, -100000, -70711};
      for (int k = 0; k < 8; k++)
         tv[k] = '{px[k], py[k], 3'(k)};
      tv[8]  = '{1024, 424, 3'd1};
      tv[9]  = '{1024, 423, 3'd0};
      tv[10] = '{424, 1024, 3'd1};
      tv[11] = '{-524288, 0, 3'd4};
      tv[12] = '{0, -524288, 3'd6};
      tv[13] = '{0, 0, 3'd1};

      bus.rx_i   = '0;
      bus.rx_q   = '0;
      bus.ena_in = 1'b0;
      bus.sof    = 1'b0;

      repeat (5) begin
         @(posedge clk);
         #1;
         bus.rx_i   = 20'($urandom);
         bus.rx_q   = 20'($urandom);
         bus.ena_in = 1'($urandom);
         bus.sof    = 1'($urandom);
         @(negedge clk);
         chk("reset_outs", {bus.sym_out, bus.sym_valid, bus.ena_out,
                            bus.frame_abort, bus.busy}, 0);
         chkv("reset_data", bus.data_8psk_rx, '0);
      end
      bus.ena_in = 1'b0;
      bus.sof    = 1'b0;
      @(posedge clk);
      #1;
      reset_b = 1'b1;
      sq.delete();
      sc.delete();
      ec.delete();
      ed.delete();
      ac.delete();

      for (int k = 0; k < 14; k++)
         send(tv[k].i, tv[k].q, 1'b0, tv[k].exp);
      flush_check("vec");
      chk("vec_no_ena", ec.size(), 0);

      repeat (300) begin
         if ($urandom_range(3) == 0) idle(1);
         if ($urandom_range(3) == 0) begin
            ri = int'($urandom_range(4000)) - 2000;
            rq = int'($urandom_range(4000)) - 2000;
         end else begin
            r  = 20'($urandom);
            ri = int'(r);
            r  = 20'($urandom);
            rq = int'(r);
         end
         send(ri, rq, 1'b0, ref_sym(ri, rq));
      end
      flush_check("rand");

      lastc = 0;
      ev    = '0;
      for (int k = 0; k < N; k++) begin
         lastc = cyc;
         send(px[k%8], py[k%8], k == 0, 3'(k % 8));
         ev[W-1-3*k -: 3] = 3'(k % 8);
         if (k == 50) chk("frame_busy_mid", bus.busy, 1);
      end
      flush_check("frame");
      chk("frame_ena_n", ec.size(), 1);
      if (ec.size() > 0) begin
         chk("frame_ena_cyc", ec[0], lastc + 3);
         chk("frame_f0", ed[0][W-1 -: 3], 0);
         chk("frame_f1", ed[0][W-4 -: 3], 1);
         chk("frame_flast", ed[0][2:0], 3);
         chkv("frame_data", ed[0], ev);
      end
      chk("frame_busy_end", bus.busy, 0);
      chk("frame_no_abort", ac.size(), 0);
      ec.delete();
      ed.delete();
      ac.delete();

      for (int k = 0; k < 50; k++) begin
         r  = 20'($urandom);
         ri = int'(r);
         r  = 20'($urandom);
         rq = int'(r);
         send(ri, rq, k == 0, ref_sym(ri, rq));
      end
      c51 = cyc;
      for (int k = 0; k < N; k++) begin
         lastc = cyc;
         send(-70711, -70711, k == 0, 3'd5);
      end
      flush_check("abort");
      chk("abort_n", ac.size(), 1);
      if (ac.size() > 0) chk("abort_cyc", ac[0], c51 + 3);
      chk("abort_ena_n", ec.size(), 1);
      for (int k = 0; k < N; k++) ev[3*k +: 3] = 3'd5;
      if (ec.size() > 0) begin
         chk("abort_ena_cyc", ec[0], lastc + 3);
         chkv("abort_data", ed[0], ev);
      end
      ec.delete();
      ed.delete();
      ac.delete();

      for (int k = 0; k < 60; k++)
         send(px[k%8], py[k%8], k == 0, 3'(k % 8));
      reset_b = 1'b0;
      idle(3);
      chk("rst_busy", bus.busy, 0);
      reset_b = 1'b1;
      sq.delete();
      sc.delete();
      xq.delete();
      xc.delete();
      for (int k = 0; k < 48; k++)
         send(px[k%8], py[k%8], 1'b0, 3'(k % 8));
      flush_check("rstmid");
      chk("rstmid_no_ena", ec.size(), 0);
      chk("rstmid_no_abort", ac.size(), 0);
      chk("rstmid_busy", bus.busy, 0);
      chkv("rstmid_data", bus.data_8psk_rx, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
